// File: rtl/fifo.sv
// fifo: DEPTH x WIDTH first-in-first-out queue with a registered read port.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_EN is defined.
module fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             write_en,
    input  logic             read_en,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic [5:0]       count
`ifdef FIFO_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [5:0]       count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             push, pop;

    assign empty    = count_q == 6'd0;
    assign full     = count_q == 6'(DEPTH);
    assign count    = count_q;
    assign data_out = data_out_q;

    // Accept decisions and next-state for pointers, occupancy, read port and storage.
    // A pop on a full queue frees the slot at rp, which equals wp, so the push may reuse it.
    always_comb begin
        push       = write_en && (!full || read_en);
        pop        = read_en && !empty;
        wp_d       = push ? wp_q + AW'(1) : wp_q;
        rp_d       = pop ? rp_q + AW'(1) : rp_q;
        count_d    = count_q + 6'(push) - 6'(pop);
        data_out_d = pop ? mem_q[rp_q] : data_out_q;
        mem_d      = mem_q;
        if (push) mem_d[wp_q] = data_in;
    end

    // Pointer, occupancy and read-port registers; reset empties the queue at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage array; contents are left as-is across reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef FIFO_ERR_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Error flags latch any rejected push or pop until reset.
    always_comb begin
        overflow_d  = overflow_q || (write_en && !push);
        underflow_d = underflow_q || (read_en && empty);
    end

    // Sticky error flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed bench for fifo with a queue-based reference model and per-cycle compare.
module tb_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = '0;
    logic        write_en = 1'b0;
    logic        read_en = 1'b0;
    logic [31:0] data_out;
    logic        empty, full;
    logic [5:0]  count;
`ifdef FIFO_ERR_EN
    logic        overflow, underflow;
`endif

    int total = 0;
    int bad = 0;

    logic [31:0] mq[$];
    logic [31:0] m_out = '0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    fifo dut (
        .clk(clk), .reset(reset), .data_in(data_in), .write_en(write_en), .read_en(read_en),
        .data_out(data_out), .empty(empty), .full(full), .count(count)
`ifdef FIFO_ERR_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a queue of at most 16 words; pop sees the old head before push appends.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_out = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            bit pu, po;
            pu = write_en && (mq.size() < 16 || read_en);
            po = read_en && mq.size() > 0;
            if (write_en && !pu) m_ovf = 1'b1;
            if (read_en && !po) m_unf = 1'b1;
            if (po) m_out = mq.pop_front();
            if (pu) mq.push_back(data_in);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("m_data_out", data_out, m_out);
            check("m_count", {26'd0, count}, mq.size());
            check("m_empty", {31'd0, empty}, {31'd0, mq.size() == 0});
            check("m_full", {31'd0, full}, {31'd0, mq.size() == 16});
`ifdef FIFO_ERR_EN
            check("m_overflow", {31'd0, overflow}, {31'd0, m_ovf});
            check("m_underflow", {31'd0, underflow}, {31'd0, m_unf});
`endif
        end
    end

    task automatic step(input logic we, input logic re, input logic [31:0] d);
        write_en = we;
        read_en = re;
        data_in = d;
        @(negedge clk);
        write_en = 1'b0;
        read_en = 1'b0;
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_count", {26'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        reset = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 32'(i));
            check("fill_count", {26'd0, count}, 32'(i));
            if (i == 1) check("fill_empty", {31'd0, empty}, 32'd0);
        end
        check("fill_full", {31'd0, full}, 32'd1);
        step(1'b1, 1'b0, 32'hDEAD);
        check("ovf_count", {26'd0, count}, 32'd16);
`ifdef FIFO_ERR_EN
        check("ovf_flag", {31'd0, overflow}, 32'd1);
`endif
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, '0);
            check("drain_data", data_out, 32'(i));
        end
        check("drain_empty", {31'd0, empty}, 32'd1);
        check("drain_count", {26'd0, count}, 32'd0);
        step(1'b0, 1'b1, '0);
        check("unf_data", data_out, 32'd16);
`ifdef FIFO_ERR_EN
        check("unf_flag", {31'd0, underflow}, 32'd1);
`endif
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h20 + 32'(i));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h100 + 32'(i));
        check("wrap_count", {26'd0, count}, 32'd12);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, '0);
            check("wrap_data", data_out, 32'h100 + 32'(i));
        end
        step(1'b1, 1'b1, 32'hA);
        check("sim_empty_count", {26'd0, count}, 32'd1);
        check("sim_empty_data", data_out, 32'h10B);
        step(1'b0, 1'b1, '0);
        check("sim_empty_pop", data_out, 32'hA);
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 32'(i));
        step(1'b1, 1'b1, 32'hB);
        check("sim_full_data", data_out, 32'd1);
        check("sim_full_count", {26'd0, count}, 32'd16);
        for (int i = 2; i <= 16; i++) begin
            step(1'b0, 1'b1, '0);
            check("sim_full_seq", data_out, 32'(i));
        end
        step(1'b0, 1'b1, '0);
        check("sim_full_last", data_out, 32'hB);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h40 + 32'(i));
        check("pre_rst_count", {26'd0, count}, 32'd5);
        #2 reset = 1'b0;
        #1;
        check("arst_count", {26'd0, count}, 32'd0);
        check("arst_empty", {31'd0, empty}, 32'd1);
        check("arst_data", data_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b1, 32'h55);
        check("post_rst_count", {26'd0, count}, 32'd1);
        check("post_rst_hold", data_out, 32'd0);
        step(1'b0, 1'b1, '0);
        check("post_rst_data", data_out, 32'h55);
        check("post_rst_empty", {31'd0, empty}, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
